// File: rtl/rst_seq_ctrl_if.sv
// Reset sequencer bus: software reset handshake
// and per-domain reset outputs.
interface rst_seq_ctrl_if #(
  parameter int NUM_STAGES = 3,
  parameter int CNT_W      = 8
);
  logic                  sw_rst_req;
  logic [CNT_W-1:0]      hold_cycles;
  logic [NUM_STAGES-1:0] stage_rst_n;
  logic                  rst_done;
  logic                  sw_rst_ack;

  modport master (
    output sw_rst_req,
    output hold_cycles,
    input  stage_rst_n,
    input  rst_done,
    input  sw_rst_ack
  );

  modport slave (
    input  sw_rst_req,
    input  hold_cycles,
    output stage_rst_n,
    output rst_done,
    output sw_rst_ack
  );
endinterface

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: init delay, staged domain release,
// done flag and software-requested reset re-run.
module rst_seq_ctrl #(
  parameter int NUM_STAGES = 3,
  parameter int INIT_DLY   = 100,
  parameter int STAGE_DLY  = 16,
  parameter int CNT_W      = 8
) (
  input  logic          clk,
  input  logic          rst,
  rst_seq_ctrl_if.slave bus
);
  localparam int SW = 3;

  typedef enum logic [1:0] {
    S_INIT,
    S_REL,
    S_DONE,
    S_HOLD
  } state_t;

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic [CNT_W-1:0]      hold_q;
  logic [SW-1:0]         stg;
  logic [NUM_STAGES-1:0] stage_q;
  logic                  done_q;
  logic                  ack_q;

  // Sequencer FSM with registered reset, done and ack outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_INIT;
      cnt     <= '0;
      hold_q  <= '0;
      stg     <= '0;
      stage_q <= '0;
      done_q  <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      unique case (state)
        S_INIT: begin
          if (cnt == CNT_W'(INIT_DLY - 1)) begin
            cnt   <= '0;
            stg   <= '0;
            state <= S_REL;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_REL: begin
          if (cnt == '0)
            stage_q <= stage_q | (NUM_STAGES'(1) << stg);
          if (cnt == CNT_W'(STAGE_DLY - 1)) begin
            cnt <= '0;
            if (stg == SW'(NUM_STAGES - 1)) begin
              state  <= S_DONE;
              done_q <= 1'b1;
            end else begin
              stg <= stg + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          if (bus.sw_rst_req) begin
            stage_q <= '0;
            done_q  <= 1'b0;
            ack_q   <= 1'b1;
            hold_q  <= (bus.hold_cycles == '0) ?
                       CNT_W'(1) : bus.hold_cycles;
            cnt     <= '0;
            state   <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (cnt == hold_q - 1'b1) begin
            cnt   <= '0;
            stg   <= '0;
            state <= S_REL;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= S_INIT;
      endcase
    end
  end

  assign bus.stage_rst_n = stage_q;
  assign bus.rst_done    = done_q;
  assign bus.sw_rst_ack  = ack_q;
endmodule
